shift_deser: RTL and testbench
==============================

SHIFT_DESER -- requirements
Module: shift_deser

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the parallel word width in bits (legal range 2..32).
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port clear, input, 1, synchronous flush of a partial word and of the overrun flag.
REQ-005 The block SHALL have port s_valid, input, 1, bit strobe; s_in is sampled only when it is high.
REQ-006 The block SHALL have port s_in, input, 1, serial data bit, LSB of the word first.
REQ-007 The block SHALL have port d_ready, input, 1, consumer accepts d_out when it is high and d_valid is high.
REQ-008 The block SHALL have port d_out, output, WIDTH, the last completed parallel word, registered.
REQ-009 The block SHALL have port d_valid, output, 1, d_out holds an unconsumed word.
REQ-010 The block SHALL have port busy, output, 1, high while a partial word is held (bit count != 0).
REQ-011 The block SHALL have port overrun, output, 1, sticky flag: a completed word was dropped.

Function
REQ-012 The block SHALL use an internal shift register sreg[WIDTH-1:0] and a bit counter cnt of width ceil(log2(WIDTH)), counting 0..WIDTH-1.
REQ-013 On a cycle with s_valid=1, the block SHALL update sreg to {s_in, sreg[WIDTH-1:1]}, so the first bit received ends in bit 0.
REQ-014 On a cycle with s_valid=1 and cnt<WIDTH-1, the block SHALL increment cnt by 1 and leave d_out and d_valid unchanged.
REQ-015 On a cycle with s_valid=1 and cnt=WIDTH-1 (word completion), the block SHALL reset cnt to 0.
REQ-016 At word completion with d_valid=0, or with d_valid=1 and d_ready=1, the block SHALL load d_out with {s_in, sreg[WIDTH-1:1]} and hold d_valid at 1.
REQ-017 At word completion with d_valid=1 and d_ready=0, the block SHALL discard the new word, keep d_out unchanged, and set overrun to 1.
REQ-018 d_valid SHALL rise on the edge that samples the WIDTH-th bit, giving one cycle of latency from the final strobe.
REQ-019 d_valid SHALL fall on the edge after a cycle with d_valid=1 and d_ready=1, unless REQ-016 reloads d_out on that same edge.
REQ-020 d_valid SHALL stay at 1 indefinitely while d_ready=0, and d_out SHALL remain stable while d_valid=1 and d_ready=0.
REQ-021 Cycles with s_valid=0 SHALL leave sreg and cnt unchanged; any gaps between strobes are legal.
REQ-022 busy SHALL equal (cnt != 0), derived from registered state.
REQ-023 overrun SHALL remain 1 until reset or clear.
REQ-024 clear=1 SHALL set cnt to 0, sreg to 0 and overrun to 0, and SHALL ignore s_valid in that cycle.
REQ-025 clear SHALL NOT change d_out or d_valid; d_ready handshakes SHALL still complete in a clear cycle.
REQ-026 Priority SHALL be reset > clear > s_valid.
REQ-027 s_in SHALL be don't-care when s_valid=0.

Reset
REQ-028 While reset=1 at a clock edge, the block SHALL set d_out=0, d_valid=0, overrun=0, busy=0, cnt=0 and sreg=0.
REQ-029 Reset asserted mid-word SHALL discard all received bits, and the next strobe after release SHALL be treated as bit 0 of a new word.
REQ-030 reset SHALL have no asynchronous effect; outputs change only at clock edges.

Verification (WIDTH=8)
REQ-031 Bench SHALL drive reset for 2 cycles, then check d_out=0x00, d_valid=0, overrun=0 and busy=0.
REQ-032 Bench SHALL send 8 back-to-back strobes with bits 1,0,1,0,0,1,0,1 and d_ready=0 -> d_valid=1 the cycle after the 8th strobe, d_out=0xA5, busy=0.
REQ-033 Bench SHALL hold d_valid=1 with d_out=0xA5 and d_ready=0, then send 8 strobes of 0x3C -> overrun=1 and d_out stays 0xA5; then pulse d_ready -> d_valid=0 on the next cycle.
REQ-034 Bench SHALL send 0x0F with random gaps in s_valid and pulse d_ready on the same cycle as the 8th strobe of 0xF0 -> d_out=0xF0, d_valid stays 1, overrun=0.
REQ-035 Bench SHALL send 3 bits, assert clear, then send 0x81 -> busy=1 after the 3 bits, busy=0 after clear, final d_out=0x81 with no stale bits.
REQ-036 Bench SHALL send 5 bits, assert reset for 1 cycle, then send 0x55 -> all outputs reset per REQ-028, then d_out=0x55 and d_valid=1 after 8 strobes.

Source files
------------

// File: rtl/shift_deser.sv
// Serial-to-parallel deserializer: LSB-first bit strobes assembled into WIDTH-bit words,
// presented on a valid/ready output register with a sticky overrun flag.
module shift_deser #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             s_valid,
  input  logic             s_in,
  input  logic             d_ready,
  output logic [WIDTH-1:0] d_out,
  output logic             d_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dvalid_q, dvalid_d;
  logic             ovr_q, ovr_d;
  logic [WIDTH-1:0] shifted;

  assign shifted = {s_in, sreg_q[WIDTH-1:1]};

  always_comb begin
    sreg_d   = sreg_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    ovr_d    = ovr_q;

    // Consumer handshake completes regardless of clear; a same-edge reload below wins.
    if (dvalid_q && d_ready) begin
      dvalid_d = 1'b0;
    end

    if (clear) begin
      sreg_d = '0;
      cnt_d  = '0;
      ovr_d  = 1'b0;
    end else if (s_valid) begin
      sreg_d = shifted;
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        if (!dvalid_q || d_ready) begin
          dout_d   = shifted;
          dvalid_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sreg_q   <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      sreg_q   <= sreg_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      ovr_q    <= ovr_d;
    end
  end

  assign d_out   = dout_q;
  assign d_valid = dvalid_q;
  assign busy    = (cnt_q != '0);
  assign overrun = ovr_q;

endmodule

// File: tb/tb_shift_deser.sv
// Self-checking bench for shift_deser (WIDTH=8): vector table, directed corner sequences,
// and randomized traffic against a bit-queue reference model.
module tb_shift_deser;

  localparam int unsigned WIDTH = 8;

  logic             clock = 1'b0;
  logic             reset, clear, s_valid, s_in, d_ready;
  logic [WIDTH-1:0] d_out;
  logic             d_valid, busy, overrun;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: received bits kept in a queue, word formed when WIDTH bits arrive.
  bit             mq[$];
  logic [WIDTH-1:0] m_dout = '0;
  logic           m_dv = 1'b0;
  logic           m_ovr = 1'b0;

  typedef struct {
    logic rst, clr, sv, si, dr;
    logic [WIDTH-1:0] e_dout;
    logic e_dv, e_busy, e_ovr;
  } vec_t;

  vec_t tbl[$];

  shift_deser #(.WIDTH(WIDTH)) dut (
    .clock  (clock),
    .reset  (reset),
    .clear  (clear),
    .s_valid(s_valid),
    .s_in   (s_in),
    .d_ready(d_ready),
    .d_out  (d_out),
    .d_valid(d_valid),
    .busy   (busy),
    .overrun(overrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_update(input logic r, c, sv, si, dr);
    logic [WIDTH-1:0] w;
    logic complete;
    complete = 1'b0;
    w = '0;
    if (r) begin
      mq.delete();
      m_dout = '0;
      m_dv   = 1'b0;
      m_ovr  = 1'b0;
    end else begin
      if (c) begin
        mq.delete();
        m_ovr = 1'b0;
      end else if (sv) begin
        mq.push_back(si);
        if (mq.size() == WIDTH) begin
          for (int i = 0; i < int'(WIDTH); i++)
            w = w + (WIDTH'(mq[i]) << i);
          mq.delete();
          complete = 1'b1;
        end
      end
      if (complete) begin
        if (!m_dv || dr) begin
          m_dout = w;
          m_dv   = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_dv && dr) begin
        m_dv = 1'b0;
      end
    end
  endtask

  // One clock: drive, advance the model across the edge, sample 1ns later.
  task automatic step(input logic r, c, sv, si, dr);
    reset = r; clear = c; s_valid = sv; s_in = si; d_ready = dr;
    @(posedge clock);
    model_update(r, c, sv, si, dr);
    #1;
    check("model_dout",    32'(d_out),   32'(m_dout));
    check("model_dvalid",  32'(d_valid), 32'(m_dv));
    check("model_busy",    32'(busy),    32'(mq.size() != 0));
    check("model_overrun", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'($urandom), 1'b0);
  endtask

  task automatic send_gaps(input logic [WIDTH-1:0] w, input logic ready_on_last);
    for (int i = 0; i < int'(WIDTH); i++) begin
      idle(int'($urandom_range(0, 3)));
      step(1'b0, 1'b0, 1'b1, w[i], (i == int'(WIDTH) - 1) ? ready_on_last : 1'b0);
    end
  endtask

  function automatic void add(input logic rst, clr, sv, si, dr,
                              input logic [WIDTH-1:0] e_dout,
                              input logic e_dv, e_busy, e_ovr);
    vec_t v;
    v.rst = rst; v.clr = clr; v.sv = sv; v.si = si; v.dr = dr;
    v.e_dout = e_dout; v.e_dv = e_dv; v.e_busy = e_busy; v.e_ovr = e_ovr;
    tbl.push_back(v);
  endfunction

  task automatic outs(input string tag, input logic [WIDTH-1:0] e_dout,
                      input logic e_dv, e_busy, e_ovr);
    check({tag, "_dout"},    32'(d_out),   32'(e_dout));
    check({tag, "_dvalid"},  32'(d_valid), 32'(e_dv));
    check({tag, "_busy"},    32'(busy),    32'(e_busy));
    check({tag, "_overrun"}, 32'(overrun), 32'(e_ovr));
  endtask

  initial begin
    logic [WIDTH-1:0] wa, wb;
    reset = 1'b1; clear = 1'b0; s_valid = 1'b0; s_in = 1'b0; d_ready = 1'b0;

    // Reset, 0xA5 capture, overrun by 0x3C, then consume.
    wa = 8'hA5;
    wb = 8'h3C;
    add(1, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    add(1, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      add(0, 0, 1, wa[i], 0, (i == 7) ? 8'hA5 : 8'h00, i == 7, i != 7, 0);
    add(0, 0, 0, 1, 0, 8'hA5, 1, 0, 0);
    add(0, 0, 0, 0, 0, 8'hA5, 1, 0, 0);
    for (int i = 0; i < 8; i++)
      add(0, 0, 1, wb[i], 0, 8'hA5, 1, i != 7, i == 7);
    add(0, 0, 0, 0, 0, 8'hA5, 1, 0, 1);
    add(0, 0, 0, 0, 1, 8'hA5, 0, 0, 1);
    add(0, 0, 0, 0, 0, 8'hA5, 0, 0, 1);

    foreach (tbl[k]) begin
      step(tbl[k].rst, tbl[k].clr, tbl[k].sv, tbl[k].si, tbl[k].dr);
      outs($sformatf("tbl%0d", k), tbl[k].e_dout, tbl[k].e_dv, tbl[k].e_busy, tbl[k].e_ovr);
    end

    // Gapped 0x0F, then 0xF0 completing on the same edge the consumer takes 0x0F.
    step(0, 1, 0, 0, 0);
    outs("clr_ovr", 8'hA5, 0, 0, 0);
    send_gaps(8'h0F, 1'b0);
    step(0, 0, 0, 0, 0);
    outs("w0F", 8'h0F, 1, 0, 0);
    send_gaps(8'hF0, 1'b1);
    outs("wF0_reload", 8'hF0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    outs("wF0_hold", 8'hF0, 1, 0, 0);

    // Partial word flushed by clear; strobe and handshake in the clear cycle.
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    outs("part3", 8'hF0, 1, 1, 0);
    step(0, 1, 1, 1, 1);
    outs("clear", 8'hF0, 0, 0, 0);
    send_gaps(8'h81, 1'b0);
    step(0, 0, 0, 0, 0);
    outs("w81", 8'h81, 1, 0, 0);

    // Mid-word reset.
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1'(i & 1), 0);
    outs("part5", 8'h81, 1, 1, 0);
    step(1, 0, 1, 1, 0);
    outs("rst_mid", 8'h00, 0, 0, 0);
    send_gaps(8'h55, 1'b0);
    step(0, 0, 0, 0, 0);
    outs("w55", 8'h55, 1, 0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 59) == 0),
           1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
